// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Constants and types shared by the key/switch conditioner and the in-game
// FSM that consumes its outputs.
//   KEY_SEL1..KEY_START : bit positions of each pushbutton within KEY
//   NUM_TILES           : number of slide switches (one per tile)
//   DEBOUNCE_DEFAULT    : 20 ms of CLOCK_50 samples
//   game_state_t        : state of the game-enable machine
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int KEY_SEL1         = 0;
    localparam int KEY_SEL2         = 1;
    localparam int KEY_QUIT         = 2;
    localparam int KEY_START        = 3;
    localparam int NUM_KEYS         = 4;
    localparam int NUM_TILES        = 10;
    localparam int DEBOUNCE_DEFAULT = 1000000;

    typedef enum logic {
        GAME_OFF = 1'b0,
        GAME_ON  = 1'b1
    } game_state_t;

endpackage : game_pkg

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// One raw asynchronous input: 2-flop synchroniser, stability counter and
// accepted-level register, plus single-cycle edge flags raised in the same
// update that accepts a new level.
//   CLOCK_50 : system clock
//   resetn   : asynchronous active-low reset
//   raw      : unsynchronised input
//   level    : debounced level (resets to RESET_LEVEL)
//   rise     : one-cycle pulse when level is accepted 0->1
//   fall     : one-cycle pulse when level is accepted 1->0
// ---------------------------------------------------------------------------
module debounce_cell #(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_s;
    logic [CNT_W-1:0] cnt;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the
    // synchroniser into a single stage.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= RESET_LEVEL;
            sync_s    <= RESET_LEVEL;
            level     <= RESET_LEVEL;
            cnt       <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_s    <= sync_meta;
            rise      <= 1'b0;
            fall      <= 1'b0;
            if (sync_s == level) begin
                // Any sample agreeing with the accepted level restarts the count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_s;
                cnt   <= '0;
                rise  <= sync_s;
                fall  <= ~sync_s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : debounce_cell

// File: rtl/key_input_conditioner.sv
// ---------------------------------------------------------------------------
// key_input_conditioner
// Cleans the DE1 pushbuttons and slide switches for the in-game FSM and owns
// the game-enable level.
//   CLOCK_50    : system clock, 50 MHz
//   resetn      : asynchronous active-low reset
//   KEY[3:0]    : raw pushbuttons, 0 = pressed (sel1, sel2, quit, start)
//   SW[9:0]     : raw slide switches, 1 = up
//   game_over   : all tiles matched, from the in-game FSM
//   select1/2   : one-cycle press pulses, suppressed when quit pulses too
//   userquit    : one-cycle press pulse of the quit key
//   start_pulse : one-cycle press pulse of the start key
//   in_game_on  : game-enable level
//   sw_clean    : debounced switch levels
//   sw_rise     : one-cycle per-switch 0->1 pulses
// ---------------------------------------------------------------------------
module key_input_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic [NUM_KEYS-1:0]  KEY,
    input  logic [NUM_TILES-1:0] SW,
    input  logic                 game_over,
    output logic                 select1,
    output logic                 select2,
    output logic                 userquit,
    output logic                 start_pulse,
    output logic                 in_game_on,
    output logic [NUM_TILES-1:0] sw_clean,
    output logic [NUM_TILES-1:0] sw_rise
);

    logic [NUM_KEYS-1:0]  key_press;
    logic [NUM_KEYS-1:0]  key_level_unused;
    logic [NUM_KEYS-1:0]  key_release_unused;
    logic [NUM_TILES-1:0] sw_fall_unused;

    // Keys idle high (released), so their cells reset to 1; a press is a fall.
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_LEVEL     (1'b1)
        ) u_cell (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .raw      (KEY[k]),
            .level    (key_level_unused[k]),
            .rise     (key_release_unused[k]),
            .fall     (key_press[k])
        );
    end

    for (genvar s = 0; s < NUM_TILES; s++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_LEVEL     (1'b0)
        ) u_cell (
            .CLOCK_50 (CLOCK_50),
            .resetn   (resetn),
            .raw      (SW[s]),
            .level    (sw_clean[s]),
            .rise     (sw_rise[s]),
            .fall     (sw_fall_unused[s])
        );
    end

    // Pulses come straight from flops; only the quit mask is gated, so no
    // input reaches an output without passing through a register.
    assign userquit    = key_press[KEY_QUIT];
    assign start_pulse = key_press[KEY_START];
    assign select1     = key_press[KEY_SEL1] & ~key_press[KEY_QUIT];
    assign select2     = key_press[KEY_SEL2] & ~key_press[KEY_QUIT];

    game_state_t state, state_next;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= GAME_OFF;
        else         state <= state_next;
    end

    // NOTE: state_next is given a default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            GAME_OFF: if (start_pulse && !userquit)  state_next = GAME_ON;
            GAME_ON:  if (userquit || game_over)     state_next = GAME_OFF;
        endcase
    end

    assign in_game_on = (state == GAME_ON);

endmodule : key_input_conditioner

// File: tb/tb_key_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_input_conditioner
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES = 4, so an
// accepted change pulses after the 6th rising edge following the raw change.
// ---------------------------------------------------------------------------
module tb_key_input_conditioner;

    localparam int DC = 4;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       game_over;
    logic       select1, select2, userquit, start_pulse, in_game_on;
    logic [9:0] sw_clean, sw_rise;

    int checks = 0;
    int errors = 0;

    key_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .KEY         (KEY),
        .SW          (SW),
        .game_over   (game_over),
        .select1     (select1),
        .select2     (select2),
        .userquit    (userquit),
        .start_pulse (start_pulse),
        .in_game_on  (in_game_on),
        .sw_clean    (sw_clean),
        .sw_rise     (sw_rise)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        KEY       = 4'hF;
        SW        = '0;
        game_over = 1'b0;
        cycles(3);
        checks++;
        if ({select1, select2, userquit, start_pulse, in_game_on} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 00000",
                     {select1, select2, userquit, start_pulse, in_game_on});
        end
        checks++;
        if ({sw_clean, sw_rise} !== 20'h0) begin
            errors++;
            $display("FAIL reset_sw got %h want 00000", {sw_clean, sw_rise});
        end
        resetn = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (select1 | select2 | userquit | start_pulse | in_game_on | (|sw_rise)) seen++;
            end
            checks++;
            if (seen != 0) begin
                errors++;
                $display("FAIL idle_after_reset got %0d active cycles want 0", seen);
            end
        end
    endtask

    task automatic test_press();
        int cnt = 0, at = -1, rel = 0;
        KEY[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (select1) begin cnt++; at = e; end
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL press_count got %0d want 1", cnt);
        end
        checks++;
        if (at != DC + 2) begin
            errors++;
            $display("FAIL press_edge got %0d want %0d", at, DC + 2);
        end
        KEY[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (select1) rel++;
        end
        checks++;
        if (rel != 0) begin
            errors++;
            $display("FAIL release_pulse got %0d want 0", rel);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pattern;
        int cnt = 0, at = -1;
        pattern = 4'b1010;  // index 0..3 -> 0,1,0,1
        for (int i = 0; i < 24; i++) begin
            KEY[1] = (i < 8) ? pattern[i/2] : 1'b0;
            tick();
            if (select2) begin cnt++; at = i; end
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL bounce_count got %0d want 1", cnt);
        end
        // Final 0 driven at i=8 (before edge 9); 6th edge from it is i=13.
        checks++;
        if (at != 8 + DC + 1) begin
            errors++;
            $display("FAIL bounce_edge got %0d want %0d", at, 8 + DC + 1);
        end
        KEY[1] = 1'b1;
        cycles(10);
    endtask

    task automatic test_game_enable();
        int cnt = 0, low = 0;
        checks++;
        if (in_game_on !== 1'b0) begin
            errors++;
            $display("FAIL enable_initial got %b want 0", in_game_on);
        end
        KEY[3] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == DC + 2) begin
                checks++;
                if ({start_pulse, in_game_on} !== 2'b10) begin
                    errors++;
                    $display("FAIL enable_pulse_edge got %b want 10", {start_pulse, in_game_on});
                end
            end
            if (e == DC + 3) begin
                checks++;
                if ({start_pulse, in_game_on} !== 2'b01) begin
                    errors++;
                    $display("FAIL enable_level_edge got %b want 01", {start_pulse, in_game_on});
                end
            end
        end
        KEY[3] = 1'b1;
        cycles(8);
        KEY[3] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (start_pulse) cnt++;
            if (!in_game_on) low++;
        end
        checks++;
        if (cnt != 1 || low != 0) begin
            errors++;
            $display("FAIL second_start got pulses=%0d off_cycles=%0d want 1 and 0", cnt, low);
        end
        KEY[3] = 1'b1;
        cycles(8);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        checks++;
        if (in_game_on !== 1'b0) begin
            errors++;
            $display("FAIL game_over got %b want 0", in_game_on);
        end
    endtask

    task automatic test_quit_priority();
        int q = 0, s1 = 0;
        KEY[3] = 1'b0;
        cycles(8);
        KEY[3] = 1'b1;
        cycles(8);
        checks++;
        if (in_game_on !== 1'b1) begin
            errors++;
            $display("FAIL quit_setup got %b want 1", in_game_on);
        end
        KEY[0] = 1'b0;
        KEY[2] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (userquit) q++;
            if (select1) s1++;
            if (e == DC + 2) begin
                checks++;
                if ({userquit, in_game_on} !== 2'b11) begin
                    errors++;
                    $display("FAIL quit_pulse_edge got %b want 11", {userquit, in_game_on});
                end
            end
            if (e == DC + 3) begin
                checks++;
                if (in_game_on !== 1'b0) begin
                    errors++;
                    $display("FAIL quit_level got %b want 0", in_game_on);
                end
            end
        end
        checks++;
        if (q != 1 || s1 != 0) begin
            errors++;
            $display("FAIL quit_priority got userquit=%0d select1=%0d want 1 and 0", q, s1);
        end
        KEY = 4'hF;
        cycles(10);
    endtask

    task automatic test_switches();
        int cnt = 0, any_rise = 0;
        logic [9:0] rv = '0;
        SW = 10'b0000000101;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (|sw_rise) begin cnt++; rv = sw_rise; end
            if (e == DC + 1) begin
                checks++;
                if (sw_clean !== 10'b0) begin
                    errors++;
                    $display("FAIL sw_clean_early got %b want 0000000000", sw_clean);
                end
            end
        end
        checks++;
        if (cnt != 1 || rv !== 10'b0000000101) begin
            errors++;
            $display("FAIL sw_rise got count=%0d value=%b want 1 and 0000000101", cnt, rv);
        end
        checks++;
        if (sw_clean !== 10'b0000000101) begin
            errors++;
            $display("FAIL sw_clean_up got %b want 0000000101", sw_clean);
        end
        SW = 10'b0000000100;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (|sw_rise) any_rise++;
        end
        checks++;
        if (sw_clean !== 10'b0000000100 || any_rise != 0) begin
            errors++;
            $display("FAIL sw_lower got clean=%b rises=%0d want 0000000100 and 0", sw_clean, any_rise);
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0, at = -1;
        KEY[3] = 1'b0;
        cycles(3);
        #3;
        resetn = 1'b0;
        SW     = '0;
        #1;
        checks++;
        if ({select1, select2, userquit, start_pulse, in_game_on, sw_clean, sw_rise} !== 25'h0) begin
            errors++;
            $display("FAIL reset_mid got %h want 0000000",
                     {select1, select2, userquit, start_pulse, in_game_on, sw_clean, sw_rise});
        end
        cycles(2);
        resetn = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (start_pulse) begin cnt++; at = e; end
        end
        checks++;
        if (cnt != 1 || at != DC + 2) begin
            errors++;
            $display("FAIL restart_pulse got count=%0d edge=%0d want 1 and %0d", cnt, at, DC + 2);
        end
        KEY[3] = 1'b1;
        cycles(8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_game_enable();
        test_quit_priority();
        test_switches();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_input_conditioner
